sysid_info_slave: RTL and testbench

//   Parametrised Avalon-MM system-ID slave; successor of the 2-word combinational sysid.

---
 rtl/sysid_pkg.sv | 27 ++
 rtl/sysid_info_slave_if.sv | 23 ++
 rtl/sysid_uptime_counter.sv | 47 ++++
 rtl/sysid_info_slave.sv | 92 +++++++++
 tb/tb_sysid_info_slave.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/sysid_pkg.sv
// Shared constants for the system-ID slave: word addresses, register count and CAPS layout.
package sysid_pkg;

  localparam logic [2:0] SYSID_A_ID     = 3'd0;
  localparam logic [2:0] SYSID_A_TSTAMP = 3'd1;
  localparam logic [2:0] SYSID_A_CAPS   = 3'd2;
  localparam logic [2:0] SYSID_A_SCR    = 3'd3;
  localparam logic [2:0] SYSID_A_UP_LO  = 3'd4;
  localparam logic [2:0] SYSID_A_UP_HI  = 3'd5;

  localparam int SYSID_NUM_REGS = 8;

  localparam int CAPS_NREGS_LSB  = 24;
  localparam int CAPS_UPTIME_BIT = 16;
  localparam int CAPS_VER_LSB    = 0;

  // CAPS is always 32 bits wide; wider buses zero-extend it.
  function automatic logic [31:0] caps_word(input logic [15:0] ver, input logic uptime_built);
    logic [31:0] w;
    w = '0;
    w[CAPS_NREGS_LSB +: 8]  = 8'(SYSID_NUM_REGS);
    w[CAPS_UPTIME_BIT]      = uptime_built;
    w[CAPS_VER_LSB +: 16]   = ver;
    return w;
  endfunction

endpackage

// File: rtl/sysid_info_slave_if.sv
// Avalon-MM slave bus for the system-ID block: fixed-latency reads, no waitrequest.
// Handshake: a read is accepted on every edge where read=1; readdatavalid is high for exactly
// one cycle one clock later with readdata. A write takes effect on its edge unless read is also high.
interface sysid_info_slave_if #(
  parameter int DATA_W = 32
);
  logic [2:0]        address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_uptime_counter.sv
// Prescaled 2*DATA_W uptime counter with a HI-half snapshot for coherent split reads.
// Only instantiated when SYSID_UPTIME_EN is defined.
module sysid_uptime_counter #(
  parameter int DATA_W   = 32,
  parameter int TICK_DIV = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_snap,
  output logic [DATA_W-1:0] o_lo,
  output logic [DATA_W-1:0] o_snap_hi
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]         r_presc;
  logic [2*DATA_W-1:0]   r_count;
  logic [DATA_W-1:0]     r_snap;
  logic                  w_tick;

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  // Clear beats a coincident tick; the counter wraps silently.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_presc <= '0;
      r_count <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) r_count <= r_count + 1'b1;
    end
  end

  // Snapshot captures the pre-edge HI on the same edge the LO half is read.
  always_ff @(posedge clock) begin
    if (!reset_n)    r_snap <= '0;
    else if (i_snap) r_snap <= r_count[2*DATA_W-1:DATA_W];
  end

  assign o_lo      = r_count[DATA_W-1:0];
  assign o_snap_hi = r_snap;

endmodule

// File: rtl/sysid_info_slave.sv
// Avalon-MM system-ID slave: 8-word map, scratch word, registered read path with readdatavalid.
// Define SYSID_UPTIME_EN to build the uptime counter (UP_LO/UP_HI, CAPS[16]=1).
module sysid_info_slave
  import sysid_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter logic [31:0] SYSTEM_ID   = 32'h0,
  parameter logic [31:0] TIMESTAMP   = 32'h0,
  parameter logic [15:0] HW_VERSION  = 16'h0002,
  parameter logic [DATA_W-1:0] SCRATCH_RST = '0,
  parameter int          TICK_DIV    = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  sysid_info_slave_if.slave   bus
);

`ifdef SYSID_UPTIME_EN
  localparam logic UPTIME_BUILT = 1'b1;
`else
  localparam logic UPTIME_BUILT = 1'b0;
`endif

  logic [DATA_W-1:0] r_scratch;
  logic [DATA_W-1:0] r_readdata;
  logic              r_rdv;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_up_lo;
  logic [DATA_W-1:0] w_up_hi;
  logic              w_rd;
  logic              w_wr;

  // A read in the same cycle as a write wins; the write is dropped.
  assign w_rd = bus.read;
  assign w_wr = bus.write & ~bus.read;

`ifdef SYSID_UPTIME_EN
  logic w_up_clear;
  logic w_up_snap;

  assign w_up_clear = w_wr && (bus.address == SYSID_A_UP_LO);
  assign w_up_snap  = w_rd && (bus.address == SYSID_A_UP_LO);

  sysid_uptime_counter #(
    .DATA_W   (DATA_W),
    .TICK_DIV (TICK_DIV)
  ) u_uptime (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_clear   (w_up_clear),
    .i_snap    (w_up_snap),
    .o_lo      (w_up_lo),
    .o_snap_hi (w_up_hi)
  );
`else
  assign w_up_lo = '0;
  assign w_up_hi = '0;
`endif

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      SYSID_A_ID:     w_rdata = DATA_W'(SYSTEM_ID);
      SYSID_A_TSTAMP: w_rdata = DATA_W'(TIMESTAMP);
      SYSID_A_CAPS:   w_rdata = DATA_W'(caps_word(HW_VERSION, UPTIME_BUILT));
      SYSID_A_SCR:    w_rdata = r_scratch;
      SYSID_A_UP_LO:  w_rdata = w_up_lo;
      SYSID_A_UP_HI:  w_rdata = w_up_hi;
      default:        w_rdata = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n)                                  r_scratch <= SCRATCH_RST;
    else if (w_wr && bus.address == SYSID_A_SCR)   r_scratch <= bus.writedata;
  end

  // readdata only moves on an accepted read so it holds between transfers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_readdata <= '0;
      r_rdv      <= 1'b0;
    end else begin
      r_rdv <= w_rd;
      if (w_rd) r_readdata <= w_rdata;
    end
  end

  assign bus.readdata      = r_readdata;
  assign bus.readdatavalid = r_rdv;

endmodule

// File: tb/tb_sysid_info_slave.sv
// Directed bench for sysid_info_slave; uptime checks follow SYSID_UPTIME_EN.
module tb_sysid_info_slave;

  localparam int          DATA_W   = 32;
  localparam logic [31:0] SYS_ID   = 32'hCAFE_0001;
  localparam logic [31:0] TSTAMP   = 32'h6650_1234;
  localparam logic [31:0] SCR_RST  = 32'h1234_5678;
  localparam int          TICK_DIV = 4;
`ifdef SYSID_UPTIME_EN
  localparam logic [31:0] CAPS_EXP = 32'h0801_0002;
`else
  localparam logic [31:0] CAPS_EXP = 32'h0800_0002;
`endif

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [DATA_W-1:0] exp_q[$];
  string             tag_q[$];

  sysid_info_slave_if #(.DATA_W(DATA_W)) bus_if ();

  sysid_info_slave #(
    .DATA_W      (DATA_W),
    .SYSTEM_ID   (SYS_ID),
    .TIMESTAMP   (TSTAMP),
    .HW_VERSION  (16'h0002),
    .SCRATCH_RST (SCR_RST),
    .TICK_DIV    (TICK_DIV)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus_if.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // drivers: called in the low clock phase, return at the following negedge
  task automatic rd(input logic [2:0] addr, input logic [DATA_W-1:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back($sformatf("rdata_a%0d", addr));
    bus_if.address = addr;
    bus_if.read    = 1'b1;
    @(negedge clk);
    bus_if.read = 1'b0;
    check("rdv_latency", bus_if.readdatavalid, 1'b1);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [DATA_W-1:0] data);
    bus_if.address   = addr;
    bus_if.writedata = data;
    bus_if.write     = 1'b1;
    @(negedge clk);
    bus_if.write = 1'b0;
  endtask

  task automatic rdwr(input logic [2:0] addr, input logic [DATA_W-1:0] data,
                      input logic [DATA_W-1:0] exp);
    bus_if.writedata = data;
    bus_if.write     = 1'b1;
    rd(addr, exp);
    bus_if.write = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (bus_if.readdatavalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_rdv", bus_if.readdatavalid, 1'b0);
      end else begin
        check(tag_q.pop_front(), bus_if.readdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n            = 1'b0;
    bus_if.address   = '0;
    bus_if.read      = 1'b0;
    bus_if.write     = 1'b0;
    bus_if.writedata = '0;
    repeat (3) @(negedge clk);
    check("reset_rdata", bus_if.readdata, '0);
    check("reset_rdv", bus_if.readdatavalid, 1'b0);
    rst_n = 1'b1;

    // back-to-back ID/TSTAMP/CAPS
    rd(3'd0, SYS_ID);
    rd(3'd1, TSTAMP);
    rd(3'd2, CAPS_EXP);
    drain();
    repeat (2) @(negedge clk);
    check("hold_rdata", bus_if.readdata, CAPS_EXP);
    check("idle_rdv", bus_if.readdatavalid, 1'b0);

    // scratch write/read, then reset mid-transfer
    wr(3'd3, 32'hDEAD_BEEF);
    rd(3'd3, 32'hDEAD_BEEF);
    drain();
    rst_n          = 1'b0;
    bus_if.address = 3'd3;
    bus_if.read    = 1'b1;
    @(negedge clk);
    bus_if.read = 1'b0;
    rst_n       = 1'b1;
    check("midrst_rdv", bus_if.readdatavalid, 1'b0);
    check("midrst_rdata", bus_if.readdata, '0);
    rd(3'd3, SCR_RST);
    drain();

`ifdef SYSID_UPTIME_EN
    // 40 clocks at TICK_DIV=4 after a clear -> 10 ticks
    wr(3'd4, '0);
    repeat (40) @(negedge clk);
    rd(3'd4, 32'd10);
    drain();

    // carry between split reads stays invisible
    wr(3'd4, '0);
    force dut.u_uptime.r_count = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.u_uptime.r_count;
    rd(3'd4, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    rd(3'd5, 32'd0);
    rd(3'd4, 32'd0);
    rd(3'd5, 32'd1);
    drain();
`else
    wr(3'd4, 32'hFFFF_FFFF);
    rd(3'd4, '0);
    rd(3'd5, '0);
    drain();
`endif

    // RO writes ignored, unused words read 0
    wr(3'd0, 32'h5555_AAAA);
    wr(3'd6, 32'h5555_AAAA);
    rd(3'd3, SCR_RST);
    rd(3'd0, SYS_ID);
    rd(3'd6, '0);
    rd(3'd7, '0);
    drain();

    // simultaneous read and write: read serviced, write dropped
    wr(3'd3, 32'h0BAD_F00D);
    rdwr(3'd3, 32'hFFFF_0000, 32'h0BAD_F00D);
    rd(3'd3, 32'h0BAD_F00D);
    drain();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
